clk_mgr: RTL and testbench
==========================

// Module: clk_mgr
// PURPOSE
//  Parametrised clock-manager model, successor to the fixed single-phase DCM pseudo-model.
//  Derives NUM_CH clock-enable/level channels from one system clock, each with a programmable divide ratio and 0/180 phase.
//  Models a lock period, a power-down request and a reconfiguration relock.
//  Sequences a synchronous reset output released after lock. Sits at top level between board clock and core/bus reset.
// PARAMETERS
//  NUM_CH       2    number of output channels (1..8)
//  DIV_W        8    width of each divide-ratio field
//  LOCK_CYCLES  16   cycles from lock start to locked=1 (>=1)
//  RST_HOLD     4    cycles from locked=1 to rst_out_ release (>=1)
//  PHASE180     0    NUM_CH-bit mask; bit i=1 inverts channel i level (180 deg)
// PORTS
//  clk       in   1              system clock
//  reset_    in   1              asynchronous reset, active low
//  pwrdn     in   1              1 = force unlock, hold channels idle
//  cfg_we    in   1              1-cycle strobe: load div_in, trigger relock
//  div_in    in   NUM_CH*DIV_W   packed divide ratios, ch0 in LSBs
//  ch_ce     out  NUM_CH         1-cycle enable pulse per channel period
//  ch_lvl    out  NUM_CH         50%-duty level per channel (phase per PHASE180)
//  locked    out  1              lock indication
//  rst_out_  out  1              synchronous reset to downstream logic, active low
// BEHAVIOUR
//  Reset (reset_=0, async): state=LOCKING, lock_cnt=0, div_reg=all 1, ch cnt=0,
//   ch_ce=0, ch_lvl=PHASE180, locked=0, rst_out_=0.
//  FSM: PDN, LOCKING, LOCKED. All outputs registered.
//   PDN: locked=0, rst_out_=0, ch_ce=0, ch_lvl=PHASE180; pwrdn=0 -> LOCKING, lock_cnt=0.
//   LOCKING: lock_cnt++; at lock_cnt==LOCK_CYCLES-1 -> LOCKED, locked=1 next edge, hold_cnt=0.
//   LOCKED: hold_cnt counts to RST_HOLD-1 then saturates; rst_out_=1 the cycle after it reaches RST_HOLD-1.
//   pwrdn=1 in any state -> PDN next edge (priority over cfg_we).
//   cfg_we=1 (pwrdn=0) in LOCKING or LOCKED: div_reg<=div_in, -> LOCKING, lock_cnt=0, locked=0,
//    rst_out_=0, channel counters cleared; cfg_we during LOCKING restarts the count.
//   cfg_we in PDN: div_reg loaded, state stays PDN.
//  Channels run only in LOCKED (counters start on first LOCKED cycle, cnt=0):
//   d = div_reg[i]; d==0 treated as 1. cnt counts 0..d-1, wraps to 0.
//   ch_ce[i]=1 on the cycle cnt==d-1, else 0; d==1 -> ch_ce[i]=1 every LOCKED cycle.
//   ch_lvl[i] = (cnt < ceil(d/2)) XOR PHASE180[i]; d==1 -> constant 1 XOR PHASE180[i].
//   Odd d: high phase is one cycle longer. Outside LOCKED: ch_ce=0, ch_lvl=PHASE180.
//  Outputs change only on clk edges except the async reset assert; reset_ release mid-lock restarts lock.
//  div_in only sampled on cfg_we; changes at other times have no effect.
// STRUCTURE
//  Shared pkg/header: FSM state encodings (PDN/LOCKING/LOCKED), clk_mgr parameter defaults,
//   counter-width macro (clog2 of LOCK_CYCLES/RST_HOLD).
//  One sub-module: clk_mgr_ch (one divider channel: cnt, ce, lvl; ports run, clear, div, phase),
//   instantiated NUM_CH times via generate; clk_mgr holds FSM, lock/hold counters, div_reg.
// TESTING
//  Reset release, pwrdn=0, defaults -> locked=1 on cycle 16 after release, rst_out_=1 four cycles later.
//  cfg_we with div ch0=4, ch1=3, PHASE180=2'b10 -> after relock ch_ce[0] every 4th cycle,
//   ch_lvl[0]=1100 repeating, ch_ce[1] every 3rd, ch_lvl[1]=001 repeating.
//  div=0 and div=1 -> ch_ce constant 1 while locked, ch_lvl constant (1 XOR phase bit).
//  cfg_we while locked -> locked and rst_out_ drop next edge, relock after 16 cycles, new ratios used.
//  pwrdn=1 together with cfg_we -> PDN wins, outputs idle; pwrdn=0 -> relock with loaded ratios.
//  reset_ asserted mid-LOCKED (between edges) -> locked=0, rst_out_=0, ch_ce=0 immediately; full relock after release.

Source files
------------

// File: rtl/clk_mgr_pkg.sv
// Shared definitions for the clock manager: FSM encoding, parameter defaults
// and the counter-width helper used to size the lock and hold counters.
package clk_mgr_pkg;

    typedef enum logic [1:0] {
        ST_PDN     = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_LOCK_CYCLES = 16;
    localparam int DEF_RST_HOLD    = 4;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_mgr_ch.sv
// One divider channel: a wrap-around counter producing a per-period enable
// pulse and a 50%-duty level, idle whenever the manager is not locked.
module clk_mgr_ch
    import clk_mgr_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    input  logic             phase,
    output logic             ce,
    output logic             lvl
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W:0]   half;
    logic             lvl_raw;

    // A ratio of zero behaves like one; the high half gets the extra cycle on odd ratios.
    always_comb begin
        d_eff   = (div == '0) ? DIV_W'(1) : div;
        half    = ({1'b0, d_eff} + (DIV_W + 1)'(1)) >> 1;
        cnt_nxt = (clear || (cnt >= d_eff - DIV_W'(1))) ? '0 : cnt + DIV_W'(1);
    end

    // Outputs are registered from the count the next cycle will carry.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt     <= '0;
            ce      <= 1'b0;
            lvl_raw <= 1'b0;
        end else if (run) begin
            cnt     <= cnt_nxt;
            ce      <= (cnt_nxt == d_eff - DIV_W'(1));
            lvl_raw <= ({1'b0, cnt_nxt} < half);
        end else begin
            cnt     <= '0;
            ce      <= 1'b0;
            lvl_raw <= 1'b0;
        end
    end

    assign lvl = lvl_raw ^ phase;

endmodule

// File: rtl/clk_mgr.sv
// Clock manager: lock/power-down/relock sequencing, sequenced reset output and
// NUM_CH programmable divider channels that run only while locked.
module clk_mgr
    import clk_mgr_pkg::*;
#(
    parameter int                NUM_CH      = DEF_NUM_CH,
    parameter int                DIV_W       = DEF_DIV_W,
    parameter int                LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int                RST_HOLD    = DEF_RST_HOLD,
    parameter logic [NUM_CH-1:0] PHASE180    = '0
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    pwrdn,
    input  logic                    cfg_we,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    output logic [NUM_CH-1:0]       ch_ce,
    output logic [NUM_CH-1:0]       ch_lvl,
    output logic                    locked,
    output logic                    rst_out_
);

    localparam int LW = cnt_w(LOCK_CYCLES);
    localparam int HW = cnt_w(RST_HOLD);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    state_t                    state, state_nxt;
    logic [LW-1:0]             lock_cnt, lock_nxt;
    logic [HW-1:0]             hold_cnt, hold_nxt;
    logic [NUM_CH*DIV_W-1:0]   div_reg, div_nxt;
    logic                      locked_nxt, rst_nxt;

    // Power-down beats reconfiguration; a reconfiguration always restarts the lock count.
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_cnt;
        hold_nxt  = hold_cnt;
        div_nxt   = cfg_we ? div_in : div_reg;
        if (pwrdn) begin
            state_nxt = ST_PDN;
        end else if (cfg_we && state != ST_PDN) begin
            state_nxt = ST_LOCKING;
            lock_nxt  = '0;
        end else begin
            unique case (state)
                ST_PDN: begin
                    state_nxt = ST_LOCKING;
                    lock_nxt  = '0;
                end
                ST_LOCKING: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_nxt = ST_LOCKED;
                        hold_nxt  = '0;
                    end else begin
                        lock_nxt = lock_cnt + LW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HW'(1);
                end
                default: state_nxt = ST_LOCKING;
            endcase
        end
        locked_nxt = (state_nxt == ST_LOCKED);
        rst_nxt    = (state == ST_LOCKED) && (state_nxt == ST_LOCKED) && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= ST_LOCKING;
            lock_cnt <= '0;
            hold_cnt <= '0;
            div_reg  <= '1;
            locked   <= 1'b0;
            rst_out_ <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_nxt;
            hold_cnt <= hold_nxt;
            div_reg  <= div_nxt;
            locked   <= locked_nxt;
            rst_out_ <= rst_nxt;
        end
    end

    // Channels restart from zero on the first locked cycle.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_mgr_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk    (clk),
            .reset_ (reset_),
            .run    (state_nxt == ST_LOCKED),
            .clear  (state != ST_LOCKED),
            .div    (div_reg[i*DIV_W +: DIV_W]),
            .phase  (PHASE180[i]),
            .ce     (ch_ce[i]),
            .lvl    (ch_lvl[i])
        );
    end

endmodule

// File: tb/tb_clk_mgr.sv
// Self-checking bench for clk_mgr: a lock-timeline model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_clk_mgr;

    localparam int         LOCK_CYCLES = 16;
    localparam int         RST_HOLD    = 4;
    localparam logic [1:0] PH          = 2'b10;

    logic        clk = 1'b0;
    logic        reset_;
    logic        pwrdn;
    logic        cfg_we;
    logic [15:0] div_in;
    logic [1:0]  ch_ce;
    logic [1:0]  ch_lvl;
    logic        locked;
    logic        rst_out_;

    int total = 0;
    int bad   = 0;

    // Model: t = cycles since the lock count started (-1 while powered down).
    int          t;
    logic [15:0] div_m;

    clk_mgr #(
        .NUM_CH      (2),
        .DIV_W       (8),
        .LOCK_CYCLES (LOCK_CYCLES),
        .RST_HOLD    (RST_HOLD),
        .PHASE180    (PH)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .pwrdn    (pwrdn),
        .cfg_we   (cfg_we),
        .div_in   (div_in),
        .ch_ce    (ch_ce),
        .ch_lvl   (ch_lvl),
        .locked   (locked),
        .rst_out_ (rst_out_)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pw, input logic we, input logic [15:0] dv);
        @(negedge clk);
        pwrdn  = pw;
        cfg_we = we;
        div_in = dv;
    endtask

    task automatic waitLocked(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (locked) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL lock_wait: locked never rose within 100 cycles");
    endtask

    function automatic logic [5:0] model_outputs(input int tt, input logic [15:0] dv);
        logic       lk, rs;
        logic [1:0] ce, lv;
        int         d, k;
        lk = (tt >= LOCK_CYCLES);
        rs = (tt >= LOCK_CYCLES + RST_HOLD);
        ce = 2'b00;
        lv = PH;
        if (lk) begin
            for (int i = 0; i < 2; i++) begin
                d = int'(dv[i*8 +: 8]);
                if (d == 0) d = 1;
                k = (tt - LOCK_CYCLES) % d;
                ce[i] = (k == d - 1);
                lv[i] = ((k < (d + 1) / 2) ? 1'b1 : 1'b0) ^ PH[i];
            end
        end
        return {lk, rs, ce, lv};
    endfunction

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            t     <= 0;
            div_m <= 16'hFFFF;
        end else begin
            if (cfg_we) div_m <= div_in;
            if (pwrdn)       t <= -1;
            else if (t < 0)  t <= 0;
            else if (cfg_we) t <= 0;
            else             t <= t + 1;
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        e = model_outputs(t, div_m);
        checkOutput("locked", int'(locked), int'(e[5]));
        checkOutput("rst_out_", int'(rst_out_), int'(e[4]));
        checkOutput("ch_ce", int'(ch_ce), int'(e[3:2]));
        checkOutput("ch_lvl", int'(ch_lvl), int'(e[1:0]));
    end

    initial begin
        int         n;
        logic [7:0] lvl0, ce0;
        logic [5:0] lvl1, ce1;

        reset_ = 1'b0;
        pwrdn  = 1'b0;
        cfg_we = 1'b0;
        div_in = 16'h0000;
        #12;
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_rst_out", int'(rst_out_), 0);
        checkOutput("reset_ch_ce", int'(ch_ce), 0);
        checkOutput("reset_ch_lvl", int'(ch_lvl), 2);

        @(negedge clk);
        reset_ = 1'b1;
        waitLocked(n);
        checkOutput("first_lock_latency", n, 16);
        n = 0;
        while (!rst_out_ && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rst_release_delay", n, 4);
        repeat (10) applyStimulus(0, 0, 16'h0000);

        // Ratios ch0=4, ch1=3; reconfiguring while locked drops lock at once.
        applyStimulus(0, 1, {8'd3, 8'd4});
        applyStimulus(0, 0, {8'd3, 8'd4});
        checkOutput("cfg_drop_locked", int'(locked), 0);
        checkOutput("cfg_drop_rst", int'(rst_out_), 0);
        waitLocked(n);
        checkOutput("cfg_relock_latency", n, 16);
        for (int k = 0; k < 8; k++) begin
            lvl0[k] = ch_lvl[0];
            ce0[k]  = ch_ce[0];
            if (k < 6) begin
                lvl1[k] = ch_lvl[1];
                ce1[k]  = ch_ce[1];
            end
            @(posedge clk);
            #1;
        end
        checkOutput("div4_lvl_pattern", int'(lvl0), 8'b0011_0011);
        checkOutput("div4_ce_pattern", int'(ce0), 8'b1000_1000);
        checkOutput("div3_lvl_pattern", int'(lvl1), 6'b100100);
        checkOutput("div3_ce_pattern", int'(ce1), 6'b100100);

        // Ratios 0 and 1 both give a pulse every cycle and a constant level.
        applyStimulus(0, 1, {8'd1, 8'd0});
        applyStimulus(0, 0, 16'h5A5A);
        waitLocked(n);
        repeat (5) applyStimulus(0, 0, 16'hA5A5);
        checkOutput("div01_ce", int'(ch_ce), 3);
        checkOutput("div01_lvl", int'(ch_lvl), 1);

        // Power-down wins over a simultaneous reconfiguration, which still loads.
        applyStimulus(1, 1, {8'd2, 8'd5});
        applyStimulus(1, 0, 16'h0000);
        checkOutput("pdn_locked", int'(locked), 0);
        repeat (3) applyStimulus(1, 0, 16'h0000);
        checkOutput("pdn_ch_ce", int'(ch_ce), 0);
        checkOutput("pdn_ch_lvl", int'(ch_lvl), 2);
        applyStimulus(0, 0, 16'h0000);
        waitLocked(n);
        checkOutput("pdn_relock_latency", n, 17);
        repeat (30) applyStimulus(0, 0, 16'h0303);

        // Asynchronous reset between edges clears outputs without waiting for a clock.
        @(posedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        checkOutput("async_locked", int'(locked), 0);
        checkOutput("async_rst_out", int'(rst_out_), 0);
        checkOutput("async_ch_ce", int'(ch_ce), 0);
        @(negedge clk);
        reset_ = 1'b1;
        waitLocked(n);
        checkOutput("reset_relock_latency", n, 16);
        repeat (25) applyStimulus(0, 0, 16'h0102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
